// File: rtl/stage_ex_pipe.sv
// stage_ex_pipe: execute stage with a single-cycle ALU path and a MUL_LAT-cycle
// multiplier path, a one-entry output register with valid/ready handshake,
// and flush/async-reset abandonment of in-flight work.
// Optional build macro STAGE_EX_MUL_EARLY_EN: a multiply with a zero operand
// completes on the single-cycle path with a zero result.
module stage_ex_pipe #(
  parameter int WIDTH   = 32,
  parameter int TID_W   = 2,
  parameter int MUL_LAT = 4,   // legal 2..8
  parameter int FLAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_flush,
  input  logic [TID_W-1:0]  ex_thread,
  input  logic [4:0]        ex_dst,
  input  logic [WIDTH-1:0]  ex_pc,
  input  logic [WIDTH-1:0]  ex_r1,
  input  logic [WIDTH-1:0]  ex_r2,
  input  logic [WIDTH-1:0]  ex_imm,
  input  logic              ex_sel_a,
  input  logic              ex_sel_b,
  input  logic [3:0]        ex_alu_func,
  input  logic              ex_flag_mul,
  input  logic [FLAG_W-1:0] ex_flags,
  output logic              tl_valid,
  input  logic              tl_ready,
  output logic [TID_W-1:0]  tl_thread,
  output logic [4:0]        tl_dst,
  output logic [WIDTH-1:0]  tl_pc,
  output logic [WIDTH-1:0]  tl_r2,
  output logic [FLAG_W-1:0] tl_flags,
  output logic              tl_flag_mul,
  output logic [WIDTH-1:0]  tl_data,
  output logic              tl_isequal,
  output logic              busy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = 3;   // holds MUL_LAT-1 for MUL_LAT up to 8
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_m1, r_m2;
  logic [WIDTH-1:0] r_data;
  logic [TID_W-1:0] r_thread;
  logic [4:0]       r_dst;
  logic [WIDTH-1:0] r_pc, r_r2;
  logic [FLAG_W-1:0] r_flags;
  logic             r_flag_mul, r_isequal;

  logic [WIDTH-1:0] w_op_a, w_op_b, w_alu, w_res, w_prod;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept, w_mul_slow, w_zero_mul, w_mul_done;

  assign ex_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && tl_ready);
  // flush swallows any request presented in the same cycle
  assign w_accept = ex_valid && ex_ready && !ex_flush;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);

`ifdef STAGE_EX_MUL_EARLY_EN
  // a zero operand makes the product trivially zero, so skip the multiplier
  assign w_mul_slow = ex_flag_mul && (ex_r1 != '0) && (ex_r2 != '0);
  assign w_zero_mul = ex_flag_mul && !w_mul_slow;
`else
  assign w_mul_slow = ex_flag_mul;
  assign w_zero_mul = 1'b0;
`endif

  assign w_op_a  = ex_sel_a ? ex_pc  : ex_r1;
  assign w_op_b  = ex_sel_b ? ex_imm : ex_r2;
  assign w_shamt = w_op_b[SHW-1:0];
  // multiplier works on the held register operands, low WIDTH bits only
  assign w_prod  = r_m1 * r_m2;
  assign w_res   = w_zero_mul ? '0 : w_alu;

  // single-cycle ALU; unused encodings yield zero
  always_comb begin
    w_alu = '0;
    case (ex_alu_func)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a & w_op_b;
      4'd3:    w_alu = w_op_a | w_op_b;
      4'd4:    w_alu = w_op_a ^ w_op_b;
      4'd5:    w_alu = w_op_a << w_shamt;
      4'd6:    w_alu = w_op_a >> w_shamt;
      4'd7:    w_alu = WIDTH'($signed(w_op_a) >>> w_shamt);
      4'd8:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      4'd9:    w_alu = {{(WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
      default: w_alu = '0;
    endcase
  end

  // control FSM: IDLE -> (MUL ->) HOLD -> IDLE, with back-to-back from HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (ex_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= w_mul_slow ? S_MUL : S_HOLD;
      r_cnt   <= w_mul_slow ? CNT_LOAD : '0;
    end else begin
      case (r_state)
        S_MUL: begin
          if (r_cnt == '0) r_state <= S_HOLD;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_HOLD:  if (tl_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // capture side-band and result on accept; multiplier result lands on its last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m1       <= '0;
      r_m2       <= '0;
      r_data     <= '0;
      r_thread   <= '0;
      r_dst      <= '0;
      r_pc       <= '0;
      r_r2       <= '0;
      r_flags    <= '0;
      r_flag_mul <= 1'b0;
      r_isequal  <= 1'b0;
    end else if (w_accept) begin
      r_m1       <= ex_r1;
      r_m2       <= ex_r2;
      r_data     <= w_res;
      r_thread   <= ex_thread;
      r_dst      <= ex_dst;
      r_pc       <= ex_pc;
      r_r2       <= ex_r2;
      r_flags    <= ex_flags;
      r_flag_mul <= ex_flag_mul;
      r_isequal  <= (ex_r1 == ex_r2);
    end else if (w_mul_done && !ex_flush) begin
      r_data     <= w_prod;
    end
  end

  assign tl_valid    = (r_state == S_HOLD);
  assign busy        = (r_state == S_MUL);
  assign tl_thread   = r_thread;
  assign tl_dst      = r_dst;
  assign tl_pc       = r_pc;
  assign tl_r2       = r_r2;
  assign tl_flags    = r_flags;
  assign tl_flag_mul = r_flag_mul;
  assign tl_data     = r_data;
  assign tl_isequal  = r_isequal;

endmodule

// File: tb/tb_stage_ex_pipe.sv
// Scoreboard bench for stage_ex_pipe: stimulus pushes hand-computed
// expectations, a monitor pops and compares on every output transfer.
module tb_stage_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_flush = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_thread = '0;
  logic [4:0]  ex_dst = '0;
  logic [31:0] ex_pc = '0, ex_r1 = '0, ex_r2 = '0, ex_imm = '0;
  logic        ex_sel_a = 1'b0, ex_sel_b = 1'b0;
  logic [3:0]  ex_alu_func = '0;
  logic        ex_flag_mul = 1'b0;
  logic [7:0]  ex_flags = '0;
  logic        tl_valid, tl_ready = 1'b1;
  logic [1:0]  tl_thread;
  logic [4:0]  tl_dst;
  logic [31:0] tl_pc, tl_r2, tl_data;
  logic [7:0]  tl_flags;
  logic        tl_flag_mul, tl_isequal, busy;

  stage_ex_pipe dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_thread(ex_thread), .ex_dst(ex_dst), .ex_pc(ex_pc), .ex_r1(ex_r1), .ex_r2(ex_r2),
    .ex_imm(ex_imm), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_alu_func(ex_alu_func),
    .ex_flag_mul(ex_flag_mul), .ex_flags(ex_flags), .tl_valid(tl_valid), .tl_ready(tl_ready),
    .tl_thread(tl_thread), .tl_dst(tl_dst), .tl_pc(tl_pc), .tl_r2(tl_r2), .tl_flags(tl_flags),
    .tl_flag_mul(tl_flag_mul), .tl_data(tl_data), .tl_isequal(tl_isequal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        iseq;
    logic [4:0]  dst;
    logic [31:0] pc;
    logic [31:0] r2;
    logic [7:0]  flags;
    logic [1:0]  thr;
    logic        mul;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_wait = 0;
  logic [4:0] tag = 5'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // present one instruction and wait (bounded) until it is accepted; ex_valid stays high
  task automatic send(input logic [3:0] f, input logic [31:0] pc, r1, r2, imm,
                      input logic sa, sb, mul, push, input logic [31:0] exp);
    int n;
    ex_alu_func = f; ex_pc = pc; ex_r1 = r1; ex_r2 = r2; ex_imm = imm;
    ex_sel_a = sa; ex_sel_b = sb; ex_flag_mul = mul;
    ex_dst = tag; ex_thread = tag[1:0]; ex_flags = {3'b101, tag};
    ex_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ex_ready && n < 64) begin @(negedge clk); n++; end
    last_wait = n;
    if (!ex_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=ex_ready0 expected=ex_ready1");
    end else if (push) begin
      q.push_back('{data: exp, iseq: (r1 == r2), dst: tag, pc: pc, r2: r2,
                    flags: {3'b101, tag}, thr: tag[1:0], mul: mul});
    end
    @(posedge clk); #1;
    tag++;
  endtask

  task automatic send1(input logic [3:0] f, input logic [31:0] pc, r1, r2, imm,
                       input logic sa, sb, mul, push, input logic [31:0] exp);
    send(f, pc, r1, r2, imm, sa, sb, mul, push, exp);
    ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every output transfer must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && tl_valid && tl_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result actual=0x%08h expected=none", tl_data);
        end else begin
          e = q.pop_front();
          chk("tl_data",     tl_data, e.data);
          chk("tl_isequal",  32'(tl_isequal), 32'(e.iseq));
          chk("tl_dst",      32'(tl_dst), 32'(e.dst));
          chk("tl_pc",       tl_pc, e.pc);
          chk("tl_r2",       tl_r2, e.r2);
          chk("tl_flags",    32'(tl_flags), 32'(e.flags));
          chk("tl_thread",   32'(tl_thread), 32'(e.thr));
          chk("tl_flag_mul", 32'(tl_flag_mul), 32'(e.mul));
        end
      end
    end
  end

  initial begin
    int n;
    // reset state
    @(negedge clk);
    chk("rst_tl_valid", 32'(tl_valid), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_tl_data",  tl_data, 0);
    chk("rst_ex_ready", 32'(ex_ready), 1);
    @(posedge clk); #2 rst = 1'b1;
    idle(1);

    // ADD pc+imm, latency 1
    send1(4'd0, 32'h100, 32'h11, 32'h22, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104);
    chk("add_latency_valid", 32'(tl_valid), 1);
    idle(2);

    // back-to-back ALU vectors
    send(4'd1, 0, 32'h5, 32'h7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    send(4'd2, 0, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00F0_1200);
    chk("b2b_no_bubble", 32'(last_wait), 0);
    send(4'd3, 0, 32'hF000_0000, 32'h0000_000F, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_000F);
    send(4'd4, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0F0_0F0F);
    send(4'd5, 0, 32'h1, 32'h0, 32'h25, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020);
    send(4'd6, 0, 32'h8000_0000, 32'h4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0800_0000);
    send(4'd7, 0, 32'h8000_0000, 32'h4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF800_0000);
    send(4'd8, 0, 32'h1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    send(4'd9, 0, 32'h1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
    send(4'd0, 0, 32'hFFFF_FFFF, 32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
    send(4'd12, 0, 32'h1234, 32'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("b2b_no_bubble_tail", 32'(last_wait), 0);
    ex_valid = 1'b0;
    idle(2);

    // MUL 7*6: busy for 4 cycles, ex_ready low
    send1(4'd0, 32'h300, 32'd7, 32'd6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd42);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_busy",     32'(busy), 1);
      chk("mul_ex_ready", 32'(ex_ready), 0);
      chk("mul_no_valid", 32'(tl_valid), 0);
    end
    @(negedge clk);
    chk("mul_done_valid", 32'(tl_valid), 1);
    chk("mul_done_busy",  32'(busy), 0);
    idle(2);
    send1(4'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1);
    idle(8);
    send1(4'd0, 0, 32'h1234_5678, 32'h10, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2345_6780);
    idle(8);

    // downstream stall: output held stable
    tl_ready = 1'b0;
    send1(4'd1, 32'h400, 32'd5, 32'd7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid",    32'(tl_valid), 1);
      chk("stall_data",     tl_data, 32'hFFFF_FFFE);
      chk("stall_ex_ready", 32'(ex_ready), 0);
    end
    @(posedge clk); #1 tl_ready = 1'b1;
    idle(2);
    chk("stall_released", 32'(tl_valid), 0);

    // flush in second MUL cycle: nothing emitted
    send1(4'd0, 32'h500, 32'd3, 32'd5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1 ex_flush = 1'b1;
    @(posedge clk); #1 ex_flush = 1'b0;
    chk("flush_valid",    32'(tl_valid), 0);
    chk("flush_busy",     32'(busy), 0);
    chk("flush_ex_ready", 32'(ex_ready), 1);
    idle(8);

    // zero-operand multiply latency
    send1(4'd0, 0, 32'd0, 32'd9, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    n = 0;
    while (!tl_valid && n < 20) begin n++; @(posedge clk); #1; end
`ifdef STAGE_EX_MUL_EARLY_EN
    chk("mul_zero_wait", 32'(n), 0);
`else
    chk("mul_zero_wait", 32'(n), 4);
`endif
    idle(3);

    // async reset mid-multiply, then SLT accepted right after release
    send1(4'd0, 32'h200, 32'd3, 32'd5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(tl_valid), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_pc",    tl_pc, 0);
    chk("arst_r2",    tl_r2, 0);
    chk("arst_dst",   32'(tl_dst), 0);
    chk("arst_data",  tl_data, 0);
    @(posedge clk); #2 rst = 1'b1;
    send1(4'd8, 0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
    chk("post_reset_first_accept", 32'(last_wait), 0);

    // drain
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    idle(2);
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
